// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing definitions for the display path.
// Holds the 640x480@60 default geometry, the derived line/frame totals and
// the control bundle type that travels through the alignment delay line.
package vga_timing_gen_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned VGA_SYNC_POL   = 0;  // 0 = active-low syncs
    localparam int unsigned VGA_CLK_DIV    = 2;  // 50 MHz clk -> 25 MHz pixel rate
    localparam int unsigned VGA_PIPE_DELAY = 1;  // renderer colour latency in clk

    // Timing decode bundle delayed to line up with the renderer's colour.
    typedef struct packed {
        logic hs_act;
        logic vs_act;
        logic video_on;
    } vga_ctl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Clock-rate shift register with asynchronous active-low reset.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears every stage
//   din   - WIDTH-bit input
//   dout  - din delayed by DEPTH clk cycles (DEPTH = 0 is a pass-through)
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and pin-side colour blanking.
// Produces the pixel strobe, scan coordinates and sync timing, and registers
// blanked renderer colour together with delayed syncs onto the VGA pins.
// Ports:
//   clk, reset_n            - system clock, asynchronous active-low reset
//   pix_r/g/b_in [3:0]      - renderer colour (PIPE_DELAY clk behind row/col)
//   row, col [31:0]         - current v_cnt / h_cnt, zero-extended
//   pix_tick                - one-clk strobe; counters advance on it
//   video_on                - undelayed active-area flag
//   frame_start             - one-clk pulse when counters wrap to (0,0)
//   frame_count [15:0]      - frames since reset, wrapping
//   vga_hs, vga_vs          - syncs to pins
//   vga_r/g/b [3:0]         - blanked colour to pins
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter int unsigned SYNC_POL   = VGA_SYNC_POL,
    parameter int unsigned CLK_DIV    = VGA_CLK_DIV,
    parameter int unsigned PIPE_DELAY = VGA_PIPE_DELAY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  pix_r_in,
    input  logic [3:0]  pix_g_in,
    input  logic [3:0]  pix_b_in,
    output logic [31:0] row,
    output logic [31:0] col,
    output logic        pix_tick,
    output logic        video_on,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CTL_W   = $bits(vga_ctl_t);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             POL      = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [HW-1:0]    h_cnt_q, h_cnt_d;
    logic [VW-1:0]    v_cnt_q, v_cnt_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             frame_wrap;

    logic             vga_hs_q, vga_hs_d;
    logic             vga_vs_q, vga_vs_d;
    logic [3:0]       vga_r_q, vga_r_d;
    logic [3:0]       vga_g_q, vga_g_d;
    logic [3:0]       vga_b_q, vga_b_d;

    vga_ctl_t         ctl_now;
    vga_ctl_t         ctl_dly;
    logic [CTL_W-1:0] ctl_dly_bits;

    // Qualified by reset_n so that with CLK_DIV = 1 the strobe is still low
    // while reset is held (div_cnt alone would read as the last phase).
    assign pix_tick = reset_n && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d     = pix_tick ? '0 : div_cnt_q + DIV_W'(1);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_wrap    = pix_tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        frame_start_d = frame_wrap;
        frame_count_d = frame_wrap ? frame_count_q + 16'd1 : frame_count_q;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end
    end

    always_comb begin
        ctl_now          = '0;
        ctl_now.hs_act   = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        ctl_now.vs_act   = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        ctl_now.video_on = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    end

    vga_delay_line #(
        .WIDTH (CTL_W),
        .DEPTH (PIPE_DELAY)
    ) u_ctl_dly (
        .clk   (clk),
        .rst_n (reset_n),
        .din   (ctl_now),
        .dout  (ctl_dly_bits)
    );

    assign ctl_dly = vga_ctl_t'(ctl_dly_bits);

    // Colour is not delayed here: the renderer already returns it PIPE_DELAY
    // clk behind row/col, so only the timing decode needs to catch up.
    always_comb begin
        vga_hs_d = ctl_dly.hs_act ? POL : ~POL;
        vga_vs_d = ctl_dly.vs_act ? POL : ~POL;
        vga_r_d  = ctl_dly.video_on ? pix_r_in : '0;
        vga_g_d  = ctl_dly.video_on ? pix_g_in : '0;
        vga_b_d  = ctl_dly.video_on ? pix_b_in : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            vga_hs_q      <= ~POL;
            vga_vs_q      <= ~POL;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
        end
    end

    assign row         = 32'(v_cnt_q);
    assign col         = 32'(h_cnt_q);
    assign video_on    = ctl_now.video_on;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunk screen geometry so that several
// whole frames fit in a short run. Expected values come from the elapsed
// clk count since reset release: pixel ticks = n / CLK_DIV, position and
// frame number follow by division, pin outputs look PIPE_DELAY+1 clk back.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 5, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 15
    localparam int VT = VA + VF + VS + VB;   // 9
    localparam int FT = HT * VT;             // ticks per frame
    localparam int CD = 2;
    localparam int PD = 1;
    localparam int POL = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  pix_r_in = '0, pix_g_in = '0, pix_b_in = '0;
    logic [31:0] row, col;
    logic        pix_tick, video_on, frame_start;
    logic [15:0] frame_count;
    logic        vga_hs, vga_vs;
    logic [3:0]  vga_r, vga_g, vga_b;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    bit hold_white = 1'b0;
    logic [11:0] hist [4096];

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL), .CLK_DIV (CD), .PIPE_DELAY (PD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_r_in    (pix_r_in),
        .pix_g_in    (pix_g_in),
        .pix_b_in    (pix_b_in),
        .row         (row),
        .col         (col),
        .pix_tick    (pix_tick),
        .video_on    (video_on),
        .frame_start (frame_start),
        .frame_count (frame_count),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // Colour presented to the DUT for the edge numbered edge_idx.
    task automatic drive_colour(input int edge_idx);
        logic [11:0] c;
        c = hold_white ? 12'hFFF : 12'($urandom);
        {pix_r_in, pix_g_in, pix_b_in} = c;
        hist[edge_idx % 4096] = c;
    endtask

    // Expected outputs after m clk edges since reset release (m = 0: reset state).
    task automatic check_state(input int m);
        int ticks, p, c, r, k, kp, kc, kr;
        logic exp_hs, exp_vs, exp_von_d;
        logic [11:0] exp_rgb;
        ticks = m / CD;
        p = ticks % FT;
        c = p % HT;
        r = p / HT;
        chk("col", col, 32'(c));
        chk("row", row, 32'(r));
        chk("pix_tick", 32'(pix_tick), 32'((m % CD) == CD - 1));
        chk("video_on", 32'(video_on), 32'(c < HA && r < VA));
        chk("frame_start", 32'(frame_start), 32'(m > 0 && (m % CD) == 0 && (ticks % FT) == 0));
        chk("frame_count", 32'(frame_count), 32'((ticks / FT) % 65536));
        k = m - PD - 1;
        if (k < 0) begin
            exp_hs = 1'(~POL);
            exp_vs = 1'(~POL);
            exp_von_d = 1'b0;
        end else begin
            kp = (k / CD) % FT;
            kc = kp % HT;
            kr = kp / HT;
            exp_hs = (kc >= HA + HF && kc < HA + HF + HS) ? 1'(POL) : 1'(~POL);
            exp_vs = (kr >= VA + VF && kr < VA + VF + VS) ? 1'(POL) : 1'(~POL);
            exp_von_d = (kc < HA && kr < VA);
        end
        exp_rgb = exp_von_d ? hist[m % 4096] : 12'h000;
        chk("vga_hs", 32'(vga_hs), 32'(exp_hs));
        chk("vga_vs", 32'(vga_vs), 32'(exp_vs));
        chk("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    endtask

    task automatic run_cycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            n++;
            #1;
            check_state(n);
            drive_colour(n + 1);
        end
    endtask

    task automatic release_reset;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        drive_colour(1);
        #1;
        check_state(0);
    endtask

    initial begin
        // Reset held for 10 clk: everything at reset values.
        reset_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_state(0);

        // Three full frames plus a partial one with random colour.
        release_reset();
        run_cycles(3 * FT * CD + 37);

        // Constant white input: blanking alone decides the pin colour.
        hold_white = 1'b1;
        drive_colour(n + 1);
        run_cycles(FT * CD);
        hold_white = 1'b0;
        drive_colour(n + 1);

        // Asynchronous reset mid-frame, at a random point between edges.
        run_cycles(int'($urandom_range(20, 150)));
        #2;
        reset_n = 1'b0;
        #1;
        check_state(0);
        repeat (3) @(posedge clk);
        #1;
        check_state(0);

        // Counters restart from (0,0) and frame_count from zero.
        release_reset();
        run_cycles(2 * FT * CD + 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA timing for the DE-10 display path and drives the row/col scan coordinates that the grid renderer consumes. It also takes the renderer's registered 4-bit colour back in. It blanks that colour outside the active area and aligns it with hsync/vsync before the values reach the VGA pins. It is the timing and pin-side end of the row/col → colour interface.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
CLK_DIV, 2, clk cycles per pixel (50 MHz → 25 MHz); must be ≥1
PIPE_DELAY, 1, renderer colour latency in clk cycles; must be ≥0

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_r_in  in  4  renderer red
pix_g_in  in  4  renderer green
pix_b_in  in  4  renderer blue
row  out  32  current vertical count (v_cnt), zero-extended
col  out  32  current horizontal count (h_cnt), zero-extended
pix_tick  out  1  one-clk strobe; counters advance on it
video_on  out  1  h_cnt<H_ACTIVE && v_cnt<V_ACTIVE (undelayed)
frame_start  out  1  one-clk pulse when counters enter (0,0)
frame_count  out  16  frames since reset, wraps
vga_hs  out  1  horizontal sync to pins
vga_vs  out  1  vertical sync to pins
vga_r  out  4  blanked red to pins
vga_g  out  4  blanked green to pins
vga_b  out  4  blanked blue to pins

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, any time, including mid-line): div_cnt=0, h_cnt=0, v_cnt=0, frame_count=0, pix_tick=0, frame_start=0.
- During reset: all delay stages cleared; vga_hs=vga_vs=~SYNC_POL (inactive); vga_r/g/b=0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick=1 combinationally when div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_tick is constant 1 after reset.
- On a clk edge with pix_tick:
  - h_cnt=H_TOTAL-1 → h_cnt=0. If v_cnt=V_TOTAL-1, then v_cnt=0; otherwise v_cnt+1.
  - Otherwise h_cnt+1.
- row/col present v_cnt/h_cnt directly, including blanking-region values. Downstream masks using video_on.
- frame_start registered: set for one clk on the edge where the counters wrap to (0,0).
- frame_count increments on that same edge and wraps at 16'hFFFF→0.
- Sync decode, combinational from the counters:
  - hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Alignment: hs_act, vs_act and video_on pass through a PIPE_DELAY-stage clk-rate shift register (not pix_tick-gated). One output register stage follows.
  - vga_hs <= hs_d ? SYNC_POL : ~SYNC_POL (vga_vs likewise).
  - vga_r <= von_d ? pix_r_in : 0 (g, b likewise).
  - Result: pin outputs lag the row/col that produced them by exactly PIPE_DELAY+1 clk. PIPE_DELAY=0 means no shift stages.
- No back-pressure and no enable input: the block free-runs continuously after reset release.
- Widths: counters are sized with $clog2(H_TOTAL) and $clog2(V_TOTAL) bits; all comparisons are done at counter width.

Decomposition:
- The shared package (game_types) gains the VGA timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL). The top level and the renderer use these instead of literals.
- One sub-module: vga_delay_line. Parameterised width and depth; async active-low reset; depth 0 is a pass-through. It is used for the {hs_act, vs_act, video_on} bundle.

Test Plan:
- Reset: hold reset_n=0 for 10 clk → vga_hs=vga_vs=1, vga_r/g/b=0, row=col=0, frame_count=0. Release → first pix_tick on the 2nd clk.
- Hsync (CLK_DIV=2): col reaches 656 → vga_hs falls 2 clk later and stays 0 for exactly 192 clk (96 ticks). It rises when col reaches 752 (+2 clk).
- Line and frame wrap: col 799 → 0 with row +1. At row=524/col=799 → row=col=0, frame_start pulses 1 clk, frame_count=1. This occurs 840,000 clk after reset release; frame_count=2 after 1,680,000 clk.
- Vsync: row 490–491 → vga_vs=0 for exactly 2×800×2 = 3200 clk per frame.
- Blanking: with pix_*_in=4'hF held constant, vga_r=F for col 0–639 and 0 for col 640–799 (2-clk lag). vga_r=0 for all of rows 480–524.
- Mid-frame reset: assert reset_n=0 at row=200, col=300 → all outputs go to reset values immediately. After release the counters restart at (0,0) and frame_count=0.
